pipeline_trace_monitor: RTL and testbench



---
 rtl/pipeline_trace_pkg.sv | 33 +++
 rtl/pipeline_trace_monitor_if.sv | 17 +
 rtl/trace_ring_buffer.sv | 72 +++++++
 rtl/pipeline_trace_monitor.sv | 135 +++++++++++++
 tb/tb_pipeline_trace_monitor.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_trace_pkg.sv
// Shared types for the pipeline trace monitor.
//   state_e        : monitor FSM state, encoded as IDLE=0, RUN=1, HALT=2, TIMEOUT=3.
//   trace_entry_t  : one captured writeback {rd, data[, pc]}.
//   idx_width()    : trace index width for a given ring depth.
// Optional feature macro: TRACE_PC_EN adds a pc field to trace_entry_t.
package pipeline_trace_pkg;

  // Stored data/pc width; the monitor's XLEN must not exceed it.
  localparam int unsigned TRACE_XLEN  = 32;
  localparam int unsigned TRACE_DEPTH = 16;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned TRACE_IDX_W = idx_width(TRACE_DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StHalt    = 2'd2,
    StTimeout = 2'd3
  } state_e;

  typedef struct packed {
    logic [4:0]            rd;
    logic [TRACE_XLEN-1:0] data;
`ifdef TRACE_PC_EN
    logic [TRACE_XLEN-1:0] pc;
`endif
  } trace_entry_t;

endpackage

// File: rtl/pipeline_trace_monitor_if.sv
// Retire-side bus watched by the trace monitor.
//   cur_pc   : PC of the instruction in fetch.
//   wb_valid : writeback stage retires a register write this cycle.
//   rd       : writeback destination register.
//   db       : writeback data bus.
// master = CPU side (drives), slave = monitor side (observes).
interface pipeline_trace_monitor_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] cur_pc;
  logic            wb_valid;
  logic [4:0]      rd;
  logic [XLEN-1:0] db;

  modport master (output cur_pc, wb_valid, rd, db);
  modport slave  (input  cur_pc, wb_valid, rd, db);
endinterface

// File: rtl/trace_ring_buffer.sv
// Circular trace store of the last DEPTH captured writebacks.
//   i_clk, i_rst : clock, synchronous active-high reset.
//   i_wr_en      : capture i_entry at the write pointer this cycle.
//   i_entry      : entry to capture.
//   i_idx        : read index, 0 = oldest valid entry.
//   o_entry      : selected entry, all zero when i_idx >= o_count.
//   o_count      : valid entries, saturating at DEPTH.
//   o_wrapped    : sticky, set once an entry has been overwritten.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module trace_ring_buffer
  import pipeline_trace_pkg::*;
#(
  parameter int unsigned  DEPTH = 16,
  localparam int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  trace_entry_t     i_entry,
  input  logic [IDX_W-1:0] i_idx,
  output trace_entry_t     o_entry,
  output logic [IDX_W:0]   o_count,
  output logic             o_wrapped
);

  trace_entry_t     r_mem [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W:0]   r_count;
  logic             r_wrapped;
  logic             w_full;
  logic [IDX_W-1:0] w_rd_addr;

  assign w_full = (r_count == (IDX_W + 1)'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head    <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_wr_en) begin
      r_wr_ptr <= r_wr_ptr + IDX_W'(1);
      if (w_full) begin
        // Ring full: the new entry lands on the oldest one, so the head moves on.
        r_head    <= r_head + IDX_W'(1);
        r_wrapped <= 1'b1;
      end else begin
        r_count <= r_count + (IDX_W + 1)'(1);
      end
    end
  end

  // Storage is not reset; stale contents are hidden by r_count.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_rst) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  always_comb begin
    w_rd_addr = r_head + i_idx;
    o_entry   = '0;
    if ({1'b0, i_idx} < r_count) begin
      o_entry = r_mem[w_rd_addr];
    end
  end

  assign o_count   = r_count;
  assign o_wrapped = r_wrapped;

endmodule

// File: rtl/pipeline_trace_monitor.sv
// Run monitor for the five-stage pipeline CPU: counts RUN cycles and retired
// writes, detects halt (PC stuck for HALT_CYCLES cycles) and timeout, and keeps
// a ring trace of the last DEPTH register writebacks.
//   i_clk, i_rst        : clock, synchronous active-high reset.
//   i_en                : start monitoring, sampled in IDLE only.
//   i_bus               : retire bus (cur_pc, wb_valid, rd, db), slave side.
//   i_trace_idx         : trace read index, 0 = oldest valid entry.
//   o_trace_rd/data/pc  : selected entry, zero when the index is past the count.
//   o_trace_count       : valid entries, saturating at DEPTH.
//   o_trace_wrapped     : sticky overwrite flag.
//   o_cycle_cnt         : cycles spent in RUN.
//   o_retire_cnt        : captured writebacks.
//   o_state, o_done     : FSM state (IDLE/RUN/HALT/TIMEOUT), terminal flag.
// Optional feature macro: TRACE_PC_EN stores cur_pc with each entry; otherwise
// o_trace_pc is tied to 0.
module pipeline_trace_monitor
  import pipeline_trace_pkg::*;
#(
  parameter int unsigned  XLEN        = 32,
  parameter int unsigned  DEPTH       = 16,
  parameter int unsigned  HALT_CYCLES = 4,
  parameter int unsigned  TIMEOUT     = 1024,
  localparam int unsigned IDX_W       = idx_width(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  pipeline_trace_monitor_if.slave i_bus,
  input  logic [IDX_W-1:0]        i_trace_idx,
  output logic [4:0]              o_trace_rd,
  output logic [XLEN-1:0]         o_trace_data,
  output logic [XLEN-1:0]         o_trace_pc,
  output logic [IDX_W:0]          o_trace_count,
  output logic                    o_trace_wrapped,
  output logic [31:0]             o_cycle_cnt,
  output logic [31:0]             o_retire_cnt,
  output logic [1:0]              o_state,
  output logic                    o_done
);

  localparam int unsigned STABLE_W = $clog2(HALT_CYCLES);

  state_e              r_state;
  state_e              w_state_d;
  logic [XLEN-1:0]     r_prev_pc;
  logic [STABLE_W-1:0] r_stable;
  logic [31:0]         r_cycle_cnt;
  logic [31:0]         r_retire_cnt;
  logic                w_pc_match;
  logic                w_halt;
  logic                w_timeout;
  logic                w_capture;
  trace_entry_t        w_entry;
  trace_entry_t        w_rd_entry;

  assign w_pc_match = (i_bus.cur_pc == r_prev_pc);
  assign w_capture  = (r_state == StRun) && i_bus.wb_valid && (i_bus.rd != 5'd0);

  always_comb begin
    w_state_d = r_state;
    w_halt    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_en) w_state_d = StRun;
      end
      StRun: begin
        // Halt when this match brings the stable count up to HALT_CYCLES-1,
        // i.e. HALT_CYCLES consecutive cycles have shown the same PC.
        w_halt    = w_pc_match && (r_stable == STABLE_W'(HALT_CYCLES - 2));
        w_timeout = (r_cycle_cnt == 32'(TIMEOUT - 1));
        if (w_halt) begin
          w_state_d = StHalt;
        end else if (w_timeout) begin
          w_state_d = StTimeout;
        end
      end
      default: ;  // HALT and TIMEOUT are left only through reset
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_prev_pc    <= '0;
      r_stable     <= '0;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StRun) begin
        r_prev_pc   <= i_bus.cur_pc;
        r_stable    <= w_pc_match ? r_stable + STABLE_W'(1) : '0;
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
        if (w_capture) r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_entry      = '0;
    w_entry.rd   = i_bus.rd;
    w_entry.data = TRACE_XLEN'(i_bus.db);
`ifdef TRACE_PC_EN
    w_entry.pc   = TRACE_XLEN'(i_bus.cur_pc);
`endif
  end

  trace_ring_buffer #(
    .DEPTH (DEPTH)
  ) u_ring (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_capture),
    .i_entry   (w_entry),
    .i_idx     (i_trace_idx),
    .o_entry   (w_rd_entry),
    .o_count   (o_trace_count),
    .o_wrapped (o_trace_wrapped)
  );

  assign o_trace_rd   = w_rd_entry.rd;
  assign o_trace_data = XLEN'(w_rd_entry.data);
`ifdef TRACE_PC_EN
  assign o_trace_pc   = XLEN'(w_rd_entry.pc);
`else
  assign o_trace_pc   = '0;
`endif

  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_retire_cnt = r_retire_cnt;
  assign o_state      = r_state;
  assign o_done       = (r_state == StHalt) || (r_state == StTimeout);

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Self-checking bench for pipeline_trace_monitor: a vector table for the basic
// run/capture behaviour, hand-written sequences for wrap, halt, timeout and
// reset corner cases, then randomized runs against a queue-based model.
module tb_pipeline_trace_monitor;
  import pipeline_trace_pkg::*;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned HALT_CYCLES = 4;
  localparam int unsigned TIMEOUT     = 32;
  localparam int unsigned IDX_W       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [IDX_W-1:0] trace_idx;
  logic [4:0]       trace_rd;
  logic [XLEN-1:0]  trace_data;
  logic [XLEN-1:0]  trace_pc;
  logic [IDX_W:0]   trace_count;
  logic             trace_wrapped;
  logic [31:0]      cycle_cnt;
  logic [31:0]      retire_cnt;
  logic [1:0]       state;
  logic             done;

  always #5 clk = ~clk;

  pipeline_trace_monitor_if #(.XLEN(XLEN)) bus ();

  pipeline_trace_monitor #(
    .XLEN        (XLEN),
    .DEPTH       (DEPTH),
    .HALT_CYCLES (HALT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_en            (en),
    .i_bus           (bus),
    .i_trace_idx     (trace_idx),
    .o_trace_rd      (trace_rd),
    .o_trace_data    (trace_data),
    .o_trace_pc      (trace_pc),
    .o_trace_count   (trace_count),
    .o_trace_wrapped (trace_wrapped),
    .o_cycle_cnt     (cycle_cnt),
    .o_retire_cnt    (retire_cnt),
    .o_state         (state),
    .o_done          (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  int          m_state  = 0;
  logic [31:0] m_cyc    = 0;
  logic [31:0] m_ret    = 0;
  logic [31:0] m_last_pc = 0;
  int          m_streak = 1;  // cycles the current PC has been seen in a row
  bit          m_wrapped = 0;

  task automatic model_step();
    ent_t e;
    if (rst) begin
      m_state = 0; m_cyc = 0; m_ret = 0; m_q.delete(); m_wrapped = 0;
      m_last_pc = 0; m_streak = 1;
    end else if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      if (bus.wb_valid && bus.rd != 5'd0) begin
        e.rd = bus.rd; e.data = bus.db; e.pc = bus.cur_pc;
        m_q.push_back(e);
        m_ret++;
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_wrapped = 1;
        end
      end
      if (bus.cur_pc == m_last_pc) m_streak++;
      else m_streak = 1;
      m_last_pc = bus.cur_pc;
      m_cyc++;
      if (m_streak >= HALT_CYCLES) m_state = 2;
      else if (m_cyc == TIMEOUT) m_state = 3;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit r, input bit e, input logic [31:0] pc, input bit v,
                       input logic [4:0] rdx, input logic [31:0] d);
    rst = r; en = e; bus.cur_pc = pc; bus.wb_valid = v; bus.rd = rdx; bus.db = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_status(input string tag, input int st, input int cyc, input int ret,
                            input int cnt, input bit wr);
    check({tag, " state"}, state, st);
    check({tag, " done"}, done, (st >= 2) ? 1 : 0);
    check({tag, " cycle_cnt"}, cycle_cnt, cyc);
    check({tag, " retire_cnt"}, retire_cnt, ret);
    check({tag, " trace_count"}, trace_count, cnt);
    check({tag, " trace_wrapped"}, trace_wrapped, wr);
  endtask

  task automatic chk_entry(input string tag, input int idx, input int rdx, input int data);
    trace_idx = IDX_W'(idx);
    #1;
    check($sformatf("%s idx%0d rd", tag, idx), trace_rd, rdx);
    check($sformatf("%s idx%0d data", tag, idx), trace_data, data);
  endtask

  task automatic chk_model(input string tag);
    int   idx;
    ent_t e;
    chk_status(tag, m_state, m_cyc, m_ret, m_q.size(), m_wrapped);
    idx = $urandom_range(0, DEPTH - 1);
    trace_idx = IDX_W'(idx);
    #1;
    e = '{rd: 5'd0, data: 32'd0, pc: 32'd0};
    if (idx < m_q.size()) e = m_q[idx];
    check($sformatf("%s idx%0d rd", tag, idx), trace_rd, e.rd);
    check($sformatf("%s idx%0d data", tag, idx), trace_data, e.data);
`ifdef TRACE_PC_EN
    check($sformatf("%s idx%0d pc", tag, idx), trace_pc, e.pc);
`else
    check($sformatf("%s idx%0d pc", tag, idx), trace_pc, 0);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          en;
    logic [31:0] pc;
    bit          wbv;
    logic [4:0]  rd;
    logic [31:0] db;
    int          idx;
    int          st;
    int          cyc;
    int          ret;
    int          cnt;
    bit          wr;
    int          e_rd;
    int          e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit e, input int pc, input bit v, input int rdx,
                              input int db, input int idx, input int st, input int cyc,
                              input int ret, input int cnt, input int erd, input int edata);
    vec_t t;
    t.rst = r; t.en = e; t.pc = pc; t.wbv = v; t.rd = 5'(rdx); t.db = db; t.idx = idx;
    t.st = st; t.cyc = cyc; t.ret = ret; t.cnt = cnt; t.wr = 1'b0;
    t.e_rd = erd; t.e_data = edata;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [31:0] pc;

    trace_idx = '0;
    drive(1, 0, 0, 0, 0, 0);

    // Reset, start, 10 idle RUN cycles, then the three-writeback pattern.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 0, 'h100 + 4 * k, 0, 0, 0, 0, 1, k, 0, 0, 0, 0);
    add(0, 0, 'h12C, 1, 5, 'h11, 0, 1, 11, 1, 1, 5, 'h11);
    add(0, 0, 'h130, 1, 0, 'h22, 0, 1, 12, 1, 1, 5, 'h11);
    add(0, 0, 'h134, 1, 7, 'h33, 1, 1, 13, 2, 2, 7, 'h33);
    add(0, 0, 'h138, 0, 0, 0, 2, 1, 14, 2, 2, 0, 0);
    add(0, 0, 'h13C, 0, 0, 0, 0, 1, 15, 2, 2, 5, 'h11);
    add(0, 0, 'h140, 1, 0, 'h55, 15, 1, 16, 2, 2, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].pc, tbl[i].wbv, tbl[i].rd, tbl[i].db);
      tick();
      chk_status($sformatf("vec%0d", i), tbl[i].st, tbl[i].cyc, tbl[i].ret, tbl[i].cnt,
                 tbl[i].wr);
      chk_entry($sformatf("vec%0d", i), tbl[i].idx, tbl[i].e_rd, tbl[i].e_data);
    end

    // Wrap: 20 captures of data 1..20 into a 16-deep ring, then reset mid-RUN.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 'h1000, 0, 0, 0); tick();
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 'h1000 + 4 * i, 1, 5'(i % 31 + 1), i); tick();
      if (i == 16) begin
        chk_status("full", 1, 16, 16, 16, 0);
        chk_entry("full", 0, 2, 1);
      end
    end
    chk_status("wrap", 1, 20, 20, 16, 1);
    chk_entry("wrap", 0, 6, 5);
    chk_entry("wrap", 15, 21, 20);
    drive(1, 0, 'h2000, 1, 4, 'h99); tick();
    chk_status("rst_mid", 0, 0, 0, 0, 0);
    chk_entry("rst_mid", 0, 0, 0);

    // Halt: PC held at 0x40 from RUN cycle 8; the halting cycle still captures.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 'h200, 0, 0, 0); tick();
    for (int k = 1; k <= 7; k++) begin drive(0, 0, 'h200 + 4 * k, 0, 0, 0); tick(); end
    for (int k = 8; k <= 10; k++) begin drive(0, 0, 'h40, 0, 0, 0); tick(); end
    chk_status("pre_halt", 1, 10, 0, 0, 0);
    drive(0, 0, 'h40, 1, 9, 'hAB); tick();
    chk_status("halt", 2, 11, 1, 1, 0);
    chk_entry("halt", 0, 9, 'hAB);
    drive(0, 0, 'h40, 1, 3, 'hCD); tick();
    drive(0, 1, 'h80, 1, 3, 'hCD); tick();
    chk_status("post_halt", 2, 11, 1, 1, 0);

    // Timeout after exactly TIMEOUT RUN cycles; the last RUN cycle captures.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 'h300, 0, 0, 0); tick();
    for (int k = 1; k <= 31; k++) begin drive(0, 0, 'h300 + 4 * k, 0, 0, 0); tick(); end
    chk_status("pre_tmo", 1, 31, 0, 0, 0);
    drive(0, 0, 'h400, 1, 2, 'h77); tick();
    chk_status("tmo", 3, 32, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin drive(0, 0, 'h500 + 4 * k, 1, 6, k); tick(); end
    chk_status("post_tmo", 3, 32, 1, 1, 0);

    // Halt and timeout in the same cycle: halt wins.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 'h600, 0, 0, 0); tick();
    for (int k = 1; k <= 28; k++) begin drive(0, 0, 'h600 + 4 * k, 0, 0, 0); tick(); end
    for (int k = 29; k <= 31; k++) begin drive(0, 0, 'h40, 0, 0, 0); tick(); end
    chk_status("pre_both", 1, 31, 0, 0, 0);
    drive(0, 0, 'h40, 0, 0, 0); tick();
    chk_status("both", 2, 32, 0, 0, 0);

    // Randomized runs against the model.
    pc = 32'h4;
    for (int run = 0; run < 60; run++) begin
      drive(1, 0, pc, 0, 0, 0); tick();
      chk_model($sformatf("rnd%0d reset", run));
      for (int c = 0, n = $urandom_range(5, 45); c < n; c++) begin
        if ($urandom_range(0, 9) >= 4) pc = ($urandom & 32'hFFFC) | 32'h4;
        drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, pc,
              $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
        tick();
        chk_model($sformatf("rnd%0d c%0d", run, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
